// File: rtl/pred_cfg_arbiter.sv
// Round-robin arbiter sharing the pred configuration bus (addr/shift/en) between
// the host command decoder (A) and the on-line auto-tuner (B), with a guard gap.
module pred_cfg_arbiter #(
  parameter int unsigned PRED_PARAMETER = 255,
  parameter int unsigned ADDR_MAX       = 4,
  parameter int unsigned GAP            = 2,
  localparam int unsigned SW = $clog2(PRED_PARAMETER + 1),
  localparam int unsigned AW = $clog2(ADDR_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [SW-1:0] shift_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [SW-1:0] shift_b,
  output logic          ack_b,
  input  logic          lock,
  output logic [AW-1:0] addr,
  output logic [SW-1:0] shift,
  output logic          en,
  output logic          err,
  output logic          busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP_WAIT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio_b_q, prio_b_d;
  logic          gnt_c, win_b_c, addr_ok_c;
  logic [AW-1:0] sel_addr_c;
  logic [SW-1:0] sel_shift_c;
  logic          en_d, ack_a_d, ack_b_d, err_d, busy_d;
  logic [AW-1:0] addr_d;
  logic [SW-1:0] shift_d;

  // Winner selection: B wins only if alone or it holds the round-robin priority
  always_comb begin
    gnt_c       = (state_q == IDLE) && !lock && (req_a || req_b);
    win_b_c     = req_b && (!req_a || prio_b_q);
    sel_addr_c  = win_b_c ? addr_b : addr_a;
    sel_shift_c = win_b_c ? shift_b : shift_a;
    addr_ok_c   = (sel_addr_c <= AW'(ADDR_MAX));
    if (sel_shift_c == SW'(0)) sel_shift_c = SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_c) state_d = ISSUE;
      ISSUE:    state_d = GAP_WAIT;
      GAP_WAIT: if (cnt_q <= CW'(1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs; strobes are prepared at grant time
  always_comb begin
    en_d     = 1'b0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr;
    shift_d  = shift;
    cnt_d    = cnt_q;
    prio_b_d = prio_b_q;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (gnt_c) begin
          ack_a_d  = !win_b_c;
          ack_b_d  = win_b_c;
          en_d     = addr_ok_c;
          err_d    = !addr_ok_c;
          prio_b_d = !win_b_c;
          if (addr_ok_c) begin
            addr_d  = sel_addr_c;
            shift_d = sel_shift_c;
          end
        end
      end
      ISSUE:    cnt_d = CW'(GAP);
      GAP_WAIT: cnt_d = cnt_q - CW'(1);
      default:  cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      addr     <= '0;
      shift    <= '0;
      cnt_q    <= '0;
      prio_b_q <= 1'b0;
    end else begin
      en       <= en_d;
      ack_a    <= ack_a_d;
      ack_b    <= ack_b_d;
      err      <= err_d;
      busy     <= busy_d;
      addr     <= addr_d;
      shift    <= shift_d;
      cnt_q    <= cnt_d;
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: tb/tb_pred_cfg_arbiter.sv
// Scoreboard bench for pred_cfg_arbiter: stimulus queues expected grants,
// a negedge monitor checks every ack against the queue.
module tb_pred_cfg_arbiter;

  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, lock;
  logic [2:0] addr_a, addr_b, addr;
  logic [7:0] shift_a, shift_b, shift;
  logic       ack_a, ack_b, en, err, busy;

  typedef struct {
    bit         port;
    bit         err;
    logic [2:0] addr;
    logic [7:0] shift;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  pred_cfg_arbiter #(.PRED_PARAMETER(255), .ADDR_MAX(4), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .shift_a(shift_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .shift_b(shift_b), .ack_b(ack_b),
    .lock(lock), .addr(addr), .shift(shift), .en(en), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input bit p, input bit e, input logic [2:0] a, input logic [7:0] s);
    exp_t x;
    x.port = p; x.err = e; x.addr = a; x.shift = s;
    return x;
  endfunction

  // Monitor: every ack must match the oldest expected transaction
  always @(negedge clk) begin
    if (rst_n && (ack_a || ack_b)) begin
      if (sbq.size() == 0) chk("unexpected_ack", 32'(ack_b), 32'(2));
      else begin
        mon_e = sbq.pop_front();
        chk("grant_port", 32'(ack_b), 32'(mon_e.port));
        chk("ack_onehot", 32'(ack_a & ack_b), 32'(0));
        chk("err", 32'(err), 32'(mon_e.err));
        chk("en", 32'(en), 32'(!mon_e.err));
        chk("addr", 32'(addr), 32'(mon_e.addr));
        chk("shift", 32'(shift), 32'(mon_e.shift));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit pb, input string nm);
    int n = 0;
    while (!(pb ? ack_b : ack_a) && n < 60) begin
      step();
      n++;
    end
    chk({nm, "_ack_seen"}, 32'(pb ? ack_b : ack_a), 32'(1));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    chk({nm, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic xfer_a(input logic [2:0] a, input logic [7:0] s, input string nm);
    req_a = 1'b1; addr_a = a; shift_a = s;
    wait_ack(1'b0, nm);
    req_a = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen, n_ack, cyc;
    int t_en[4];
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; lock = 1'b0;
    addr_a = '0; addr_b = '0; shift_a = '0; shift_b = '0;
    repeat (3) step();
    chk("rst_en", 32'(en), 0);
    chk("rst_ack", 32'({ack_a, ack_b}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr_shift", 32'({addr, shift}), 0);
    rst_n = 1'b1;
    step();

    // Basic write: one-cycle latency, busy for 1+GAP cycles
    sbq.push_back(mk(1'b0, 1'b0, 3'd2, 8'd10));
    req_a = 1'b1; addr_a = 3'd2; shift_a = 8'd10;
    step();
    chk("t1_en_latency", 32'(en), 1);
    chk("t1_ack_latency", 32'(ack_a), 1);
    req_a = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk("t1_busy_len", 32'(n), 32'(GAP + 1));

    // Out-of-range address: ack+err, bus outputs keep previous value
    sbq.push_back(mk(1'b1, 1'b1, 3'd2, 8'd10));
    req_b = 1'b1; addr_b = 3'd5; shift_b = 8'd77;
    wait_ack(1'b1, "t3");
    chk("t3_err", 32'(err), 1);
    chk("t3_no_en", 32'(en), 0);
    req_b = 1'b0;
    wait_idle("t3");

    // Contested: B served last so A wins first, then alternate
    sbq.push_back(mk(1'b0, 1'b0, 3'd1, 8'd3));
    sbq.push_back(mk(1'b1, 1'b0, 3'd3, 8'd200));
    sbq.push_back(mk(1'b0, 1'b0, 3'd1, 8'd3));
    sbq.push_back(mk(1'b1, 1'b0, 3'd3, 8'd200));
    req_a = 1'b1; addr_a = 3'd1; shift_a = 8'd3;
    req_b = 1'b1; addr_b = 3'd3; shift_b = 8'd200;
    n_ack = 0; cyc = 0;
    while (n_ack < 4 && cyc < 200) begin
      step();
      cyc++;
      if (en) begin
        t_en[n_ack] = cyc;
        n_ack++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("t2_n_strobes", 32'(n_ack), 4);
    for (int i = 1; i < 4; i++)
      chk("t2_strobe_period", 32'(t_en[i] - t_en[i-1]), 32'(GAP + 2));
    wait_idle("t2");

    // Shift clamp and top valid address
    sbq.push_back(mk(1'b0, 1'b0, 3'd0, 8'd1));
    xfer_a(3'd0, 8'd0, "t4_zero");
    sbq.push_back(mk(1'b0, 1'b0, 3'd4, 8'd255));
    xfer_a(3'd4, 8'd255, "t4_max");

    // Lock holds off a pending request; grant one cycle after release
    sbq.push_back(mk(1'b0, 1'b0, 3'd1, 8'd5));
    lock = 1'b1; req_a = 1'b1; addr_a = 3'd1; shift_a = 8'd5;
    seen = 0;
    repeat (20) begin
      step();
      if (en || ack_a || ack_b || busy) seen++;
    end
    chk("t5_locked_quiet", 32'(seen), 0);
    lock = 1'b0;
    step();
    chk("t5_en_after_unlock", 32'(en), 1);
    chk("t5_ack_after_unlock", 32'(ack_a), 1);
    req_a = 1'b0;
    wait_idle("t5a");

    // Lock raised mid-transfer: current strobe and gap complete, no new grant
    sbq.push_back(mk(1'b1, 1'b0, 3'd2, 8'd9));
    req_b = 1'b1; addr_b = 3'd2; shift_b = 8'd9;
    wait_ack(1'b1, "t5b");
    lock = 1'b1; req_b = 1'b0;
    req_a = 1'b1; addr_a = 3'd3; shift_a = 8'd3;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk("t5_inflight_busy_len", 32'(n), 32'(GAP + 1));
    seen = 0;
    repeat (5) begin
      step();
      if (ack_a || en) seen++;
    end
    chk("t5_relocked_quiet", 32'(seen), 0);
    sbq.push_back(mk(1'b0, 1'b0, 3'd3, 8'd3));
    lock = 1'b0;
    wait_ack(1'b0, "t5c");
    req_a = 1'b0;
    wait_idle("t5c");

    // Async reset during ISSUE, then contested grant goes to A
    req_a = 1'b1; addr_a = 3'd3; shift_a = 8'd7;
    step();
    chk("t6_issue_en", 32'(en), 1);
    rst_n = 1'b0; req_a = 1'b0;
    #1;
    chk("t6_rst_en", 32'(en), 0);
    chk("t6_rst_ack", 32'({ack_a, ack_b}), 0);
    chk("t6_rst_err_busy", 32'({err, busy}), 0);
    step();
    rst_n = 1'b1;
    step();
    sbq.push_back(mk(1'b0, 1'b0, 3'd1, 8'd3));
    req_a = 1'b1; addr_a = 3'd1; shift_a = 8'd3;
    req_b = 1'b1; addr_b = 3'd3; shift_b = 8'd200;
    wait_ack(1'b0, "t6");
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("t6");

    repeat (5) step();
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
